// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the baud divisor helper
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  // Clock cycles per bit period; shared so TX and RX can never disagree on bit timing.
  function automatic int unsigned baud_divisor(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a selectable reset value so
// idle-high lines do not glitch active on reset release.
module sync_2ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: synchronized rx, mid-bit sampling, valid/ack holding register
// with framing-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned BAUD_DIVISOR = baud_divisor(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_DIVISOR = BAUD_DIVISOR / 2;
  localparam int unsigned CNT_W        = $clog2(BAUD_DIVISOR);
  localparam int unsigned BIT_W        = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIVISOR - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]                data_out_d;
  logic                      data_valid_d;
  logic                      frame_error_d;
  logic                      overrun_d;

  // rx idles high, so the synchronizer resets to 1 to avoid a false start after reset.
  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_out    <= data_out_d;
      data_valid  <= data_valid_d;
      frame_error <= frame_error_d;
      overrun     <= overrun_d;
      busy        <= (state_d != IDLE);
    end
  end

  // Next-state and output logic; a byte completion takes priority over a same-cycle ack.
  always_comb begin
    state_d       = state_q;
    baud_cnt_d    = baud_cnt_q + 1'b1;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out;
    data_valid_d  = data_valid & ~data_ack;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (baud_cnt_q == CNT_HALF) begin
          baud_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (baud_cnt_q == CNT_FULL) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (baud_cnt_q == CNT_FULL) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            overrun_d    = data_valid & ~data_ack;
            state_d      = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_IDLE;
          end
        end
      end

      // A held-low line (break) must return high before a new start can be detected.
      WAIT_IDLE: begin
        baud_cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        baud_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver; frames are generated from the 8N1
// line format and results compared against expected bytes and flag counts.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int unsigned CLOCK_FREQ = 1_000_000;
  localparam int unsigned BAUD_RATE  = 100_000;
  localparam int BAUD    = 10;
  localparam int HALF    = 5;
  localparam int EXP_LAT = HALF + 9 * BAUD + 3;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       rx       = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  int cyc        = 0;
  int fe_cycles  = 0;
  int ov_cycles  = 0;
  int rise_cnt   = 0;
  int rise_cyc   = 0;
  int start_cyc  = 0;
  logic dv_prev  = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit done = 1'b0;

  uart_receiver #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_ack    (data_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Observer: counts flag pulses and captures each rising edge of data_valid.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (reset) begin
      fe_cycles = fe_cycles + int'(frame_error);
      ov_cycles = ov_cycles + int'(overrun);
      if (data_valid && !dv_prev) begin
        rise_cnt = rise_cnt + 1;
        rise_cyc = cyc;
        got_q.push_back(data_out);
      end
      dv_prev = data_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one 8N1 frame: start 0, data LSB first, then the given stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits      = {stop, b, 1'b0};
    start_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BAUD) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int meas_lat;
    int r0, f0, o0, g0, lat, busy_low;
    logic [7:0] bits7e [10];
    logic [9:0] frame7e;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single frame 0xA5 with latency check and ack
    r0 = rise_cnt; f0 = fe_cycles;
    send_frame(8'hA5, 1'b1);
    check("t1_rise_count", 32'(rise_cnt - r0), 32'd1);
    check("t1_data_out", 32'(data_out), 32'hA5);
    check("t1_data_valid", 32'(data_valid), 32'h1);
    check("t1_frame_error", 32'(fe_cycles - f0), 32'd0);
    lat = rise_cyc - start_cyc;
    vectors++;
    assert (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1) else begin
      miscompares++;
      $error("FAIL t1_latency: observed %0d expected %0d+-1", lat, EXP_LAT);
    end
    meas_lat = (lat < 1) ? 1 : ((lat > 150) ? 150 : lat);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("t1_ack_clears", 32'(data_valid), 32'h0);

    // 2: short glitch is rejected
    repeat (10) @(negedge clk);
    r0 = rise_cnt; f0 = fe_cycles;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_busy_in_start", 32'(busy), 32'h1);
    rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("t2_busy_idle", 32'(busy), 32'h0);
    repeat (20) @(negedge clk);
    check("t2_no_valid", 32'(rise_cnt - r0), 32'd0);
    check("t2_no_fe", 32'(fe_cycles - f0), 32'd0);
    check("t2_data_kept", 32'(data_out), 32'hA5);

    // 3: framing error followed by a held break
    r0 = rise_cnt; f0 = fe_cycles;
    send_frame(8'h3C, 1'b0);
    busy_low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
    check("t3_busy_held", 32'(busy_low), 32'd0);
    check("t3_fe_one_cycle", 32'(fe_cycles - f0), 32'd1);
    check("t3_no_valid", 32'(data_valid), 32'h0);
    check("t3_data_kept", 32'(data_out), 32'hA5);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("t3_busy_release", 32'(busy), 32'h0);
    repeat (20) @(negedge clk);
    check("t3_no_retrigger_fe", 32'(fe_cycles - f0), 32'd1);
    check("t3_no_rise", 32'(rise_cnt - r0), 32'd0);

    // 4a: overrun with no ack
    o0 = ov_cycles; f0 = fe_cycles;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("t4_overrun_once", 32'(ov_cycles - o0), 32'd1);
    check("t4_data_out", 32'(data_out), 32'h22);
    check("t4_data_valid", 32'(data_valid), 32'h1);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    repeat (5) @(negedge clk);

    // 4b: ack coincides with completion, completion wins
    send_frame(8'h11, 1'b1);
    check("t4b_first_valid", 32'(data_valid), 32'h1);
    o0 = ov_cycles;
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (meas_lat) @(negedge clk);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check("t4b_valid_kept", 32'(data_valid), 32'h1);
        check("t4b_data_out", 32'(data_out), 32'h22);
      end
    join
    @(negedge clk);
    check("t4b_no_overrun", 32'(ov_cycles - o0), 32'd0);
    check("t4b_valid_still", 32'(data_valid), 32'h1);

    // 5: reset mid-DATA of 0x7E, then a clean 0xC3
    frame7e = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 10; i++) bits7e[i] = 8'(frame7e[i]);
    for (int i = 0; i < 4; i++) begin
      rx = bits7e[i][0];
      repeat (BAUD) @(negedge clk);
    end
    rx = bits7e[4][0];
    repeat (4) @(negedge clk);
    check("t5_busy_mid_frame", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_data_out", 32'(data_out), 32'h00);
    check("t5_rst_valid", 32'(data_valid), 32'h0);
    check("t5_rst_fe", 32'(frame_error), 32'h0);
    check("t5_rst_ov", 32'(overrun), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    f0 = fe_cycles; o0 = ov_cycles;
    send_frame(8'hC3, 1'b1);
    check("t5_data_out", 32'(data_out), 32'hC3);
    check("t5_data_valid", 32'(data_valid), 32'h1);
    check("t5_no_flags", 32'(fe_cycles - f0 + ov_cycles - o0), 32'd0);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    repeat (5) @(negedge clk);

    // 6: back-to-back stream from a behavioural transmitter, acked as it arrives
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    g0 = got_q.size(); f0 = fe_cycles; o0 = ov_cycles;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < exp_q.size(); i++) begin
          send_frame(exp_q[i], 1'b1);
          if (i >= 3) repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        done = 1'b1;
      end
      begin
        for (int n = 0; n < 5000; n++) begin
          if (done) break;
          @(negedge clk);
          data_ack = data_valid && !data_ack;
        end
        data_ack = 1'b0;
      end
    join
    check("t6_byte_count", 32'(got_q.size() - g0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i < got_q.size())
        check($sformatf("t6_byte%0d", i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
    end
    check("t6_no_fe", 32'(fe_cycles - f0), 32'd0);
    check("t6_no_overrun", 32'(ov_cycles - o0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART 8N1 receiver for the HC-05 Bluetooth link, mirroring the existing UART transmitter. It synchronizes the asynchronous rx line and detects start bits. Each bit is sampled at mid-bit using the same baud divisor as the transmitter. Received bytes go to the host-side logic through a valid/ack holding register, with framing-error and overrun flags.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in baud; BAUD_DIVISOR = CLOCK_FREQ / BAUD_RATE, HALF_DIVISOR = BAUD_DIVISOR / 2

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx  input  1  serial line, idle high, asynchronous to clk
data_ack  input  1  consumer has taken data_out; clears data_valid
data_out  output  8  last correctly framed byte, LSB received first
data_valid  output  1  level; high while an unacknowledged byte is held
frame_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: new byte completed while data_valid high and data_ack low
busy  output  1  state != IDLE

Behaviour:
- One clock, asynchronous active-low reset. All flops reset on the falling edge of reset, independent of clk.
- Reset values: data_out=8'h00, data_valid=0, frame_error=0, overrun=0, busy=0. Synchronizer flops reset to 1, state=IDLE, counters=0.
- rx passes through a 2-flop synchronizer giving rx_s. The FSM uses only rx_s.
- Baud counter width is $clog2(BAUD_DIVISOR). The counter is held at 0 in IDLE and WAIT_IDLE. It clears on every sample point and on every state change.
- States:
  - IDLE: go to START when rx_s==0.
  - START: when counter==HALF_DIVISOR-1, sample rx_s. If 0, go to DATA with bit_counter=0. If 1 (glitch or false start), return to IDLE with no flags.
  - DATA: when counter==BAUD_DIVISOR-1, shift rx_s into the MSB of the shift register (right shift, so the LSB arrives first). After bit_counter==7, go to STOP; otherwise increment bit_counter.
  - STOP: when counter==BAUD_DIVISOR-1, sample rx_s.
    - If 1: data_out<=shift_reg, data_valid<=1. overrun pulses if data_valid was 1 and data_ack is 0 in that cycle. Go to IDLE.
    - If 0: frame_error pulses. data_out and data_valid are unchanged. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from re-triggering start detection.
- data_ack clears data_valid on the next edge.
- If data_ack and a byte completion occur in the same cycle, the completion wins: data_valid stays 1, data_out takes the new byte, and overrun does not pulse.
- If an overrun occurs, the new byte overwrites data_out.
- Latency: data_valid rises HALF_DIVISOR + 9*BAUD_DIVISOR + 3 cycles after the first clk edge that sees rx low. The bench tolerance is ±1 cycle.
- Reset during a frame aborts it immediately. The next valid frame after reset release is received normally.
- Back-to-back frames: a start bit that begins immediately after the stop-bit sample point is detected. The receiver tolerates ±2% baud mismatch.

Decomposition:
- Shared package uart_pkg holds:
  - the enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}, 3 bits
  - the function baud_divisor(clock_freq, baud_rate)
  - the UART_DATA_BITS=8 constant
- The transmitter migrates to the same package function.
- One natural sub-module, sync_2ff: a parameterized-reset-value 2-flop synchronizer, reusable for other asynchronous inputs.

Test Plan (bench uses CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so BAUD_DIVISOR=10 and HALF_DIVISOR=5):
1. Drive a frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_out=8'hA5, data_valid=1 at 98±1 cycles after the start edge is seen, frame_error=0. Pulse data_ack -> data_valid=0 on the next cycle.
2. Drive rx low for 3 cycles, then high -> no data_valid and no frame_error, and busy returns to 0 within 8 cycles.
3. Drive 0x3C with the stop bit low, then hold rx low for 30 cycles -> frame_error pulses for exactly 1 cycle, data_valid stays 0, and busy stays 1 until rx returns high.
4. Send 0x11 then 0x22 with no data_ack -> overrun pulses once at the second stop sample, data_out=8'h22, data_valid=1. Repeat with data_ack asserted exactly at the second completion cycle -> no overrun pulse.
5. Assert reset mid-DATA of a frame for 0x7E -> all outputs are at reset values immediately (asynchronously). After release, sending 0xC3 -> data_out=8'hC3, data_valid=1.
6. Loopback uart_transmitter.tx to rx and send 0x00, 0xFF, 0x55 back-to-back -> three data_valid events with matching bytes, no frame_error, no overrun (each acknowledged).
